// File: rtl/ioctl_upload_reader.sv
`default_nettype none
// ============================================================================
// Module      : ioctl_upload_reader
// Description : Host-read side of the ioctl channel. It answers HPS upload
//               requests by reading core memory and returning one byte per
//               ioctl_rd strobe on ioctl_din. ioctl_wait is held high while a
//               memory read is in flight. Addresses at or above MEM_BYTES read
//               back as 8'hFF without touching memory.
//               Optional feature macro: UPLOAD_CSUM_EN adds a 16-bit running
//               sum of the returned bytes on csum. Without it, csum is tied
//               to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module ioctl_upload_reader #(
    parameter int         ADDR_W       = 16,
    parameter int         RD_LAT       = 2,
    parameter logic [7:0] UPLOAD_INDEX = 8'd2,
    parameter int         MEM_BYTES    = 2048
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_upload,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_rd,
    input  logic [24:0]       ioctl_addr,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_q,
    output logic              busy,
    output logic              upload_done,
    output logic [15:0]       csum
);

    localparam int                CNT_W       = (RD_LAT > 1) ? $clog2(RD_LAT + 1) : 1;
    localparam logic [CNT_W-1:0]  C_CNT_INIT  = CNT_W'(RD_LAT);
    localparam logic [CNT_W-1:0]  C_CNT_LAST  = CNT_W'(1);
    // One bit wider than ioctl_addr so MEM_BYTES = 2**25 still compares correctly
    localparam logic [25:0]       C_MEM_LIMIT = 26'(MEM_BYTES);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_LAT  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [7:0]        r_din;
    logic [7:0]        w_din_nxt;
    logic              w_din_ld;
    logic              r_wait;
    logic              w_wait_nxt;
    logic              r_mem_rd;
    logic              w_mem_rd_nxt;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [ADDR_W-1:0] w_mem_addr_nxt;
    logic              r_done;
    logic              r_active_q;
    logic              w_active;
    logic              w_fall;
    logic              w_in_range;

    assign w_active   = ioctl_upload && (ioctl_index == UPLOAD_INDEX);
    assign w_fall     = r_active_q && !w_active;
    // Full 25-bit compare: high address bits must not alias into memory
    assign w_in_range = ({1'b0, ioctl_addr} < C_MEM_LIMIT);

    // Next-state and next-output decode; session end overrides a read in flight
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_din_nxt      = r_din;
        w_din_ld       = 1'b0;
        w_wait_nxt     = r_wait;
        w_mem_rd_nxt   = 1'b0;
        w_mem_addr_nxt = r_mem_addr;
        case (r_state)
            S_IDLE: begin
                if (ioctl_rd && w_active) begin
                    if (w_in_range) begin
                        w_mem_addr_nxt = ioctl_addr[ADDR_W-1:0];
                        w_mem_rd_nxt   = 1'b1;
                        w_wait_nxt     = 1'b1;
                        w_cnt_nxt      = C_CNT_INIT;
                        w_state_nxt    = S_LAT;
                    end else begin
                        w_din_nxt = 8'hFF;
                        w_din_ld  = 1'b1;
                    end
                end
            end
            S_LAT: begin
                if (w_fall) begin
                    w_wait_nxt  = 1'b0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == C_CNT_LAST) begin
                    w_din_nxt   = mem_q;
                    w_din_ld    = 1'b1;
                    w_wait_nxt  = 1'b0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - C_CNT_LAST;
                end
            end
            default: begin
                w_wait_nxt  = 1'b0;
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_din      <= 8'h00;
            r_wait     <= 1'b0;
            r_mem_rd   <= 1'b0;
            r_mem_addr <= '0;
            r_done     <= 1'b0;
            r_active_q <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_wait     <= w_wait_nxt;
            r_mem_rd   <= w_mem_rd_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            r_done     <= w_fall;
            r_active_q <= w_active;
            if (w_din_ld) begin
                r_din <= w_din_nxt;
            end
        end
    end

`ifdef UPLOAD_CSUM_EN
    logic r_csum_unused_rise;
    logic [15:0] r_csum;
    logic        w_rise;

    assign w_rise = w_active && !r_active_q;

    // Running sum of every byte returned to the host, restarted per session
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_csum <= 16'h0000;
        end else if (w_rise || w_din_ld) begin
            r_csum <= (w_rise ? 16'h0000 : r_csum)
                    + (w_din_ld ? {8'h00, w_din_nxt} : 16'h0000);
        end
    end

    assign csum = r_csum;
`else
    assign csum = 16'h0000;
`endif

    assign ioctl_din   = r_din;
    assign ioctl_wait  = r_wait;
    assign mem_rd      = r_mem_rd;
    assign mem_addr    = r_mem_addr;
    assign busy        = (r_state != S_IDLE);
    assign upload_done = r_done;

endmodule
`default_nettype wire
